// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL bit
// positions, reset values and the default register-window base address.
package mmio_timer_pkg;

  localparam int unsigned TIMER_XLEN    = 32;
  localparam int unsigned TIMER_PRESC_W = 8;

  // Default base of the 16-byte register window (16-byte aligned).
  localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_F000;

  // Word offsets within the window, taken from memAddr[3:2].
  typedef enum logic [1:0] {
    TIMER_CTRL    = 2'd0,
    TIMER_STATUS  = 2'd1,
    TIMER_COUNT   = 2'd2,
    TIMER_COMPARE = 2'd3
  } timer_reg_e;

  // CTRL field positions.
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_AUTO_CLR = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_PRESC_LO = 8;
  localparam int unsigned CTRL_PRESC_HI = 15;

  // Implemented CTRL bits; everything else is stored and read as zero.
  localparam logic [31:0] CTRL_MASK   = 32'h0000_FF07;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for the timer: pcnt runs 0..div while en is high and emits a
// one-cycle tick when it reaches div, then restarts at 0.
// Ports: clk, reset (sync, active-high), en (count enable), clr (restart
// pcnt at 0), div (terminal value), tick (combinational, en & pcnt == div).
module mmio_timer_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] pcnt_q;

  assign tick = en & (pcnt_q == div);

  // pcnt holds while disabled; a clear wins over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (clr || tick) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= pcnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer on the core's data-memory bus: prescaled 32-bit
// up-counter, compare register, sticky MATCH flag and level interrupt.
// Ports: clk, reset (sync, active-high), memAddr/memWr/wrMask/memWriteData
// (core write side, lanes already shifted), memReadData (combinational read
// data, 0 outside the window), sel (address in window), irq (MATCH & IRQ_EN).
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int unsigned      XLEN      = TIMER_XLEN,
  parameter logic [XLEN-1:0]  BASE_ADDR = TIMER_BASE_ADDR,
  parameter int unsigned      PRESC_W   = TIMER_PRESC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] memAddr,
  input  logic            memWr,
  input  logic [3:0]      wrMask,
  input  logic [XLEN-1:0] memWriteData,
  output logic [XLEN-1:0] memReadData,
  output logic            sel,
  output logic            irq
);

  logic [XLEN-1:0] ctrl_q, count_q, compare_q;
  logic            match_q;
  logic [XLEN-1:0] ctrl_wr, count_wr, compare_wr;
  timer_reg_e      off;
  logic            wr_ctrl, wr_status, wr_count, wr_compare;
  logic            tick, hit, w1c, pcnt_clr;
  logic [1:0]      unused_addr_lsb;

  assign unused_addr_lsb = memAddr[1:0];
  assign off             = timer_reg_e'(memAddr[3:2]);
  assign sel             = (memAddr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);

  assign wr_ctrl    = memWr & sel & (off == TIMER_CTRL);
  assign wr_status  = memWr & sel & (off == TIMER_STATUS);
  assign wr_count   = memWr & sel & (off == TIMER_COUNT);
  assign wr_compare = memWr & sel & (off == TIMER_COMPARE);

  // Byte-lane merge: unmasked lanes keep the current register value.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign ctrl_wr[8*i +: 8]    = wrMask[i] ? memWriteData[8*i +: 8] : ctrl_q[8*i +: 8];
    assign count_wr[8*i +: 8]   = wrMask[i] ? memWriteData[8*i +: 8] : count_q[8*i +: 8];
    assign compare_wr[8*i +: 8] = wrMask[i] ? memWriteData[8*i +: 8] : compare_q[8*i +: 8];
  end

  // Touching the PRESC byte restarts the prescaler phase.
  assign pcnt_clr = wr_ctrl & wrMask[1];
  assign w1c      = wr_status & wrMask[0] & memWriteData[0];

  mmio_timer_prescaler #(
    .WIDTH (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (pcnt_clr),
    .div   (ctrl_q[CTRL_PRESC_LO +: PRESC_W]),
    .tick  (tick)
  );

  // Compare against the pre-write COMPARE value.
  assign hit = tick & (count_q == compare_q);

  // Register state; software COUNT writes beat the tick, MATCH set beats W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      count_q   <= '0;
      compare_q <= XLEN'(COMPARE_RST);
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_wr & XLEN'(CTRL_MASK);
      end
      if (wr_compare) begin
        compare_q <= compare_wr;
      end
      if (wr_count) begin
        count_q <= count_wr;
      end else if (tick) begin
        count_q <= (hit && ctrl_q[CTRL_AUTO_CLR]) ? '0 : count_q + XLEN'(1);
      end
      if (hit) begin
        match_q <= 1'b1;
      end else if (w1c) begin
        match_q <= 1'b0;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    memReadData = '0;
    if (sel) begin
      unique case (off)
        TIMER_CTRL:    memReadData = ctrl_q;
        TIMER_STATUS:  memReadData = XLEN'(match_q);
        TIMER_COUNT:   memReadData = count_q;
        TIMER_COMPARE: memReadData = compare_q;
        default:       memReadData = '0;
      endcase
    end
  end

  assign irq = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer.sv
`timescale 1ns/100ps
module tb_mmio_timer;

  localparam logic [31:0] BASE      = 32'h0000_F000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0;
  localparam logic [31:0] A_STATUS  = BASE + 32'h4;
  localparam logic [31:0] A_COUNT   = BASE + 32'h8;
  localparam logic [31:0] A_COMPARE = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr;
  logic        memWr;
  logic [3:0]  wrMask;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        sel;
  logic        irq;

  mmio_timer dut (
    .clk          (clk),
    .reset        (reset),
    .memAddr      (memAddr),
    .memWr        (memWr),
    .wrMask       (wrMask),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .sel          (sel),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register contents plus enabled cycles since last tick.
  logic [31:0] m_ctrl, m_count, m_cmp;
  bit          m_match;
  int unsigned m_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return m_ctrl;
      2'd1:    return {31'h0, m_match};
      2'd2:    return m_count;
      default: return m_cmp;
    endcase
  endfunction

  // Read every register (random low address bits) and irq against the model.
  task automatic probe();
    logic [31:0] a;
    memWr = 1'b0;
    for (int o = 0; o < 4; o++) begin
      a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      memAddr = a;
      #1;
      check($sformatf("rd_off%0d", o), memReadData, m_read(a));
    end
    check("irq", 32'(irq), 32'(m_match & m_ctrl[2]));
  endtask

  // One clock cycle with the given bus transaction; the model advances with it.
  task automatic step(input bit rst, input logic [31:0] addr, input bit wr,
                      input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] n_ctrl, n_count, n_cmp;
    bit          n_match, tick, hit, inwin;
    int unsigned n_phase;
    probe();
    reset = rst; memAddr = addr; memWr = wr; wrMask = mask; memWriteData = data;
    #1;
    inwin = (addr[31:4] == BASE[31:4]);
    check("sel", 32'(sel), 32'(inwin));
    check("rd_bus", memReadData, m_read(addr));

    tick    = m_ctrl[0] && (m_phase == 32'(m_ctrl[15:8]));
    hit     = tick && (m_count == m_cmp);
    n_ctrl  = m_ctrl;
    n_cmp   = m_cmp;
    n_match = m_match;
    n_phase = !m_ctrl[0] ? m_phase : (tick ? 0 : m_phase + 1);
    n_count = !tick ? m_count : ((hit && m_ctrl[1]) ? 32'h0 : m_count + 32'h1);
    if (wr && inwin) begin
      case (addr[3:2])
        2'd0: begin
          n_ctrl = merge(m_ctrl, data, mask) & 32'h0000_FF07;
          if (mask[1]) n_phase = 0;
        end
        2'd1:    if (mask[0] && data[0]) n_match = 0;
        2'd2:    n_count = merge(m_count, data, mask);
        default: n_cmp = merge(m_cmp, data, mask);
      endcase
    end
    if (hit) n_match = 1;

    @(posedge clk);
    #1;
    m_ctrl = n_ctrl; m_count = n_count; m_cmp = n_cmp; m_match = n_match; m_phase = n_phase;
    if (rst) model_reset();
    reset = 1'b0; memWr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    step(0, a, 1, 4'hF, d);
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memWr = 1'b0; memAddr = a;
    #1;
    check(tag, memReadData, exp);
  endtask

  task automatic rand_step();
    logic [31:0] addr, data;
    logic [3:0]  mask;
    int unsigned off;
    off  = $urandom_range(0, 3);
    addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) addr = $urandom;
    mask = 4'($urandom);
    if ($urandom_range(0, 1) == 0) mask = 4'hF;
    case (off)
      0: data = {16'($urandom), 8'($urandom_range(0, 3)), 5'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0)};
      1: data = $urandom;
      default: begin
        case ($urandom_range(0, 3))
          0:       data = $urandom;
          1:       data = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: data = 32'($urandom_range(0, 24));
        endcase
      end
    endcase
    step($urandom_range(0, 199) == 0, addr, $urandom_range(0, 3) == 0, mask, data);
  endtask

  initial begin
    reset = 1'b1; memAddr = '0; memWr = 1'b0; wrMask = '0; memWriteData = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset state and address decode.
    check_reg("t1_ctrl", A_CTRL, 32'h0);
    check_reg("t1_status", A_STATUS, 32'h0);
    check_reg("t1_count", A_COUNT, 32'h0);
    check_reg("t1_compare", A_COMPARE, 32'hFFFF_FFFF);
    check("t1_irq", 32'(irq), 32'h0);
    memAddr = 32'h0000_EFFC; #1;
    check("t1_sel_below", 32'(sel), 32'h0);
    check("t1_rd_below", memReadData, 32'h0);
    memAddr = 32'h0000_F00C; #1;
    check("t1_sel_top", 32'(sel), 32'h1);

    // Auto-clear match at COMPARE = 5, then W1C.
    wr32(A_COMPARE, 32'd5);
    wr32(A_CTRL, 32'h0000_0007);
    for (int k = 0; k < 6; k++) begin
      check_reg("t2_count_seq", A_COUNT, 32'(k));
      check_reg("t2_status_pre", A_STATUS, 32'h0);
      idle(1);
    end
    check_reg("t2_count_clr", A_COUNT, 32'h0);
    check_reg("t2_match", A_STATUS, 32'h1);
    check("t2_irq_hi", 32'(irq), 32'h1);
    wr32(A_STATUS, 32'h1);
    check("t2_irq_lo", 32'(irq), 32'h0);

    // Prescale by 4.
    step(1, 32'h0, 0, 4'h0, 32'h0);
    wr32(A_CTRL, 32'h0000_0301);
    idle(40);
    check_reg("t3_count", A_COUNT, 32'd10);

    // Byte-lane write.
    step(1, 32'h0, 0, 4'h0, 32'h0);
    wr32(A_COUNT, 32'h1122_3344);
    step(0, A_COUNT, 1, 4'b0100, 32'h00AA_0000);
    check_reg("t4_bytewr", A_COUNT, 32'h11AA_3344);

    // Wrap does not match; match on the following value.
    step(1, 32'h0, 0, 4'h0, 32'h0);
    wr32(A_COUNT, 32'hFFFF_FFFF);
    wr32(A_COMPARE, 32'h0);
    wr32(A_CTRL, 32'h0000_0001);
    check_reg("t5_count_ff", A_COUNT, 32'hFFFF_FFFF);
    idle(1);
    check_reg("t5_count_wrap", A_COUNT, 32'h0);
    check_reg("t5_nomatch", A_STATUS, 32'h0);
    idle(1);
    check_reg("t5_count_1", A_COUNT, 32'h1);
    check_reg("t5_match", A_STATUS, 32'h1);

    // Simultaneous events, then reset mid-count.
    step(1, 32'h0, 0, 4'h0, 32'h0);
    wr32(A_COMPARE, 32'd3);
    wr32(A_CTRL, 32'h0000_0005);
    idle(3);
    wr32(A_STATUS, 32'h1);
    check_reg("t6_set_wins", A_STATUS, 32'h1);
    check_reg("t6_count4", A_COUNT, 32'd4);
    wr32(A_STATUS, 32'h1);
    check_reg("t6_cleared", A_STATUS, 32'h0);
    wr32(A_COUNT, 32'd3);
    check_reg("t6_wr_wins", A_COUNT, 32'd3);
    wr32(A_COUNT, 32'h100);
    check_reg("t6_wr_on_hit", A_COUNT, 32'h100);
    check_reg("t6_hit_match", A_STATUS, 32'h1);
    check("t6_irq", 32'(irq), 32'h1);
    idle(2);
    step(1, 32'h0, 0, 4'h0, 32'h0);
    check_reg("t6_rst_ctrl", A_CTRL, 32'h0);
    check_reg("t6_rst_status", A_STATUS, 32'h0);
    check_reg("t6_rst_count", A_COUNT, 32'h0);
    check_reg("t6_rst_compare", A_COMPARE, 32'hFFFF_FFFF);
    check("t6_rst_irq", 32'(irq), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) rand_step();
    probe();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral and responder on the CPU data-memory interface.
- Receives the address, write enable, byte write mask and write data that the core drives, and returns read data in the same cycle, since the core is single-cycle with combinational reads.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt.
- Sits beside data RAM behind the top-level address decode.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- BASE_ADDR, 32'h0000_F000, base of the 16-byte register window; must be 16-byte aligned.
- PRESC_W, 8, prescaler field width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- memAddr  in  32  byte address from core
- memWr  in  1  write enable from core
- wrMask  in  4  byte-lane write mask, already lane-shifted by core
- memWriteData  in  32  write data, already lane-shifted by core
- memReadData  out  32  read data to core, combinational
- sel  out  1  high when memAddr[31:4] == BASE_ADDR[31:4]
- irq  out  1  interrupt, level = MATCH & IRQ_EN

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Register map (offset = memAddr[3:2]; memAddr[1:0] ignored):
  - 0x0 CTRL: [0] EN, [1] AUTO_CLR, [2] IRQ_EN, [15:8] PRESC. All other bits read 0.
  - 0x4 STATUS: [0] MATCH, sticky. Write 1 to clear, write 0 has no effect.
  - 0x8 COUNT: read/write.
  - 0xC COMPARE: read/write.
- Reset values:
  - CTRL = 0, STATUS = 0, COUNT = 0, COMPARE = 32'hFFFF_FFFF, prescaler counter = 0.
  - irq = 0.
  - memReadData follows the reset register values.
- Reads:
  - memReadData = selected register when sel is high, else 32'h0. Zero latency.
  - Reads have no side effects.
- Writes:
  - Occur on posedge clk when memWr & sel.
  - Byte lane i is updated only if wrMask[i]. Unmasked lanes hold their value.
  - For STATUS, the clear takes effect only if lane 0 is written with bit 0 = 1.
- Prescaler:
  - pcnt counts 0..PRESC while EN=1 and holds at its value while EN=0.
  - tick = EN & (pcnt == PRESC). On tick, pcnt returns to 0.
  - PRESC = 0 gives a tick every cycle.
  - Any write touching CTRL lane 1 clears pcnt.
- Counter, on tick:
  - If COUNT == COMPARE: set MATCH. COUNT <= AUTO_CLR ? 0 : COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - 32'hFFFF_FFFF + 1 wraps to 0; wrap alone does not set MATCH.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick takes priority; the increment is discarded.
  - A MATCH set and a W1C clear in the same cycle leave MATCH = 1 (set wins).
  - A COMPARE write and a tick in the same cycle: the compare uses the old COMPARE.
- Disable: clearing EN freezes COUNT and pcnt. MATCH keeps its value.
- irq: combinational AND of the MATCH and IRQ_EN flops (glitch-free). Rises one cycle after the matching tick edge.
- Reset mid-count: all state returns to reset values on the next posedge. No pending tick survives.
- No bus errors: out-of-window accesses are ignored, with memReadData = 0.

Decomposition:
- Shared constants header (constants.vh):
  - register offsets TIMER_CTRL/STATUS/COUNT/COMPARE;
  - CTRL bit positions EN/AUTO_CLR/IRQ_EN and the PRESC field bounds;
  - the default BASE_ADDR.
- One sub-module: prescaler. Inputs: clk, reset, en, clr, div. Output: tick. Parameter: width.
- Byte-mask merge stays inline as a per-register generate loop.

Test Plan:
1. Reset, then read all four offsets -> 0, 0, 0, 32'hFFFF_FFFF; irq = 0; sel = 0 for memAddr 32'h0000_EFFC.
2. Write COMPARE = 5, then CTRL = 32'h0000_0007 (PRESC = 0) -> COUNT 0..5 on consecutive cycles, MATCH = 1 on the cycle after COUNT = 5, COUNT = 0 (auto-clear), irq = 1; write STATUS = 1 -> irq = 0.
3. CTRL = 32'h0000_0301 (PRESC = 3, EN) -> COUNT increments once every 4 cycles; after 40 cycles COUNT = 10.
4. Byte write: COUNT = 32'h1122_3344, then wrMask = 4'b0100 with data 32'h00AA_0000 -> COUNT reads 32'h11AA_3344; EN = 0 throughout.
5. COUNT = 32'hFFFF_FFFF, COMPARE = 0, AUTO_CLR = 0, EN = 1, PRESC = 0 -> COUNT = 0 next cycle with MATCH = 0, then COUNT = 1 with MATCH = 1.
6. Same cycle as a matching tick, write STATUS = 1 and COUNT = 32'h100 -> MATCH stays 1 and COUNT = 32'h100 (write wins); assert reset mid-count -> all registers back to reset values next edge.
